instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 147 ++++++++++++++
 tb/tb_instr_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RISC-V word encoder: packs I/S(/R) fields into 32-bit words at sequential addresses.
// Build option: INSTR_ENC_RTYPE_EN enables R-type (0110011) encoding.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [15:0] rem_q;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_addr_q;
  logic        out_err_q;
  logic        done_q;

  logic [31:0] instr_d;
  logic        err_d;
  logic        imm_ok;
  logic        is_i;
  logic        is_s;
  logic        acc;
  logic        out_fire;

  assign is_i = (opcode == 7'b0000011) ||
                (opcode == 7'b0010011) ||
                (opcode == 7'b1100111);
  assign is_s = (opcode == 7'b0100011);
  assign imm_ok = (imm[31:11] == {21{imm[11]}});

`ifdef INSTR_ENC_RTYPE_EN
  logic is_r;
  assign is_r = (opcode == 7'b0110011);
`else
  logic unused_f7;
  assign unused_f7 = ^funct7;
`endif

  always_comb begin
    instr_d = NOP;
    err_d   = 1'b1;
    unique case (1'b1)
      is_i: begin
        if (imm_ok) begin
          instr_d = {imm[11:0], rs1, funct3, rd, opcode};
          err_d   = 1'b0;
        end
      end
      is_s: begin
        if (imm_ok) begin
          instr_d = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
          err_d   = 1'b0;
        end
      end
`ifdef INSTR_ENC_RTYPE_EN
      is_r: begin
        instr_d = {funct7, rs2, rs1, funct3, rd, opcode};
        err_d   = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign acc      = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_fire) out_valid_q <= 1'b0;
      // a new word may land in the same cycle the old one leaves
      if (acc) begin
        out_valid_q <= 1'b1;
        out_instr_q <= instr_d;
        out_err_q   <= err_d;
        out_addr_q  <= addr_q;
        addr_q      <= addr_q + 32'd4;
        rem_q       <= rem_q - 16'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (len == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              addr_q  <= base_addr;
              rem_q   <= len;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (acc && rem_q == 16'd1) state_q <= DRAIN;
        end
        DRAIN: begin
          if (out_fire) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, errors, stall, wrap, reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [6:0] op, input logic [4:0] d,
                        input logic [2:0] f3, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [6:0] f7,
                        input logic [31:0] im);
    opcode = op; rd = d; funct3 = f3;
    rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
  endtask

  task automatic run1(input string tag, input logic [31:0] base,
                      input logic [6:0] op, input logic [4:0] d,
                      input logic [2:0] f3, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [6:0] f7,
                      input logic [31:0] im, input logic [31:0] ei,
                      input logic ee);
    @(negedge clk);
    start = 1'b1; base_addr = base; len = 16'd1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    set_in(op, d, f3, s1, s2, f7, im);
    in_valid = 1'b1;
    #1 chk({tag, ".rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".vld"}, out_valid, 1);
    chk({tag, ".instr"}, out_instr, ei);
    chk({tag, ".addr"}, out_addr, base);
    chk({tag, ".err"}, out_err, ee);
    #1 chk({tag, ".drain_rdy"}, in_ready, 0);
    @(negedge clk);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".vld0"}, out_valid, 0);
    chk({tag, ".idle"}, busy, 0);
    @(negedge clk);
    chk({tag, ".done0"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    set_in('0, '0, '0, '0, '0, '0, '0);
    #2;
    chk("rst.vld", out_valid, 0);
    chk("rst.instr", out_instr, 0);
    chk("rst.addr", out_addr, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rdy", in_ready, 0);
    chk("rst.done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run1("addi", 32'h100, 7'b0010011, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0,
         32'd5, 32'h00510093, 1'b0);
    run1("sw", 32'h200, 7'b0100011, 5'd0, 3'b010, 5'd2, 5'd5, 7'd0,
         32'd8, 32'h00512423, 1'b0);
    run1("lw", 32'h204, 7'b0000011, 5'd3, 3'b010, 5'd1, 5'd0, 7'd0,
         32'hFFFFFFFC, 32'hFFC0A183, 1'b0);
    run1("jalr", 32'h208, 7'b1100111, 5'd1, 3'd0, 5'd5, 5'd0, 7'd0,
         32'hFFFFFFFC, 32'hFFC280E7, 1'b0);
    run1("imm800", 32'h300, 7'b0010011, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0,
         32'h00000800, 32'h00000013, 1'b1);
    run1("immneg", 32'h304, 7'b0100011, 5'd0, 3'b010, 5'd2, 5'd5, 7'd0,
         32'hFFFFF7FF, 32'h00000013, 1'b1);
    run1("badop", 32'h308, 7'b1111111, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0,
         32'd5, 32'h00000013, 1'b1);
`ifdef INSTR_ENC_RTYPE_EN
    run1("add", 32'h30C, 7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0,
         32'd0, 32'h002081B3, 1'b0);
`else
    run1("add", 32'h30C, 7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0,
         32'd0, 32'h00000013, 1'b1);
`endif

    // zero-length run: immediate done, never busy
    @(negedge clk);
    start = 1'b1; len = 16'd0; base_addr = 32'h400;
    @(negedge clk);
    start = 1'b0;
    chk("len0.done", done, 1);
    chk("len0.busy", busy, 0);
    @(negedge clk);
    chk("len0.done0", done, 0);

    // four words, sink stalled for three cycles, then streaming
    start = 1'b1; base_addr = 32'h100; len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    set_in(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    @(negedge clk);
    chk("st.a0", out_addr, 32'h100);
    chk("st.i0", out_instr, 32'h00100093);
    set_in(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2);
    out_ready = 1'b0;
    #1 chk("st.rdy0", in_ready, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("st.hold_v", out_valid, 1);
      chk("st.hold_i", out_instr, 32'h00100093);
      chk("st.hold_a", out_addr, 32'h100);
      if (c == 0) begin
        start = 1'b1; base_addr = 32'h500; len = 16'd0;
      end else begin
        start = 1'b0;
      end
      #1 chk("st.hold_rdy", in_ready, 0);
    end
    chk("st.nodone", done, 0);
    out_ready = 1'b1;
    #1 chk("st.rel_rdy", in_ready, 1);
    @(negedge clk);
    chk("st.a1", out_addr, 32'h104);
    chk("st.i1", out_instr, 32'h00200113);
    set_in(7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
    @(negedge clk);
    chk("st.a2", out_addr, 32'h108);
    chk("st.i2", out_instr, 32'h00300193);
    set_in(7'b0010011, 5'd4, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4);
    @(negedge clk);
    chk("st.a3", out_addr, 32'h10C);
    chk("st.i3", out_instr, 32'h00400213);
    chk("st.v3", out_valid, 1);
    chk("st.nodone3", done, 0);
    #1 chk("st.drain_rdy", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("st.done", done, 1);
    chk("st.idle", busy, 0);

    // address wrap, then reset mid-run after two of four words
    @(negedge clk);
    start = 1'b1; base_addr = 32'hFFFFFFFC; len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    set_in(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    @(negedge clk);
    chk("wr.a0", out_addr, 32'hFFFFFFFC);
    set_in(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2);
    @(negedge clk);
    chk("wr.a1", out_addr, 32'h0);
    chk("wr.i1", out_instr, 32'h00200113);
    rst_n = 1'b0;
    #1;
    chk("mr.vld", out_valid, 0);
    chk("mr.instr", out_instr, 0);
    chk("mr.addr", out_addr, 0);
    chk("mr.err", out_err, 0);
    chk("mr.busy", busy, 0);
    chk("mr.rdy", in_ready, 0);
    chk("mr.done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mr.rdy_post", in_ready, 0);
    @(negedge clk);
    chk("mr.vld_post", out_valid, 0);
    chk("mr.busy_post", busy, 0);
    chk("mr.rdy_post2", in_ready, 0);
    in_valid = 1'b0;

    run1("after_rst", 32'h100, 7'b0010011, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0,
         32'd5, 32'h00510093, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
